// File: rtl/retire_stage_pkg.sv
// Shared types for the retire stage: ROB exit packet, register index types, FSM states.
// Superscalar width comes from the N macro (default 4).
`ifndef N
`define N 4
`endif

package retire_stage_pkg;
   localparam int N_SCALAR = `N;
   localparam int ARCH_W   = 5;
   localparam int PHYS_W   = 6;

   typedef logic [ARCH_W-1:0] ARCH_REG_IDX;
   typedef logic [PHYS_W-1:0] PHYS_REG_IDX;

   typedef struct packed {
      logic        completed;
      logic        has_dest;
      ARCH_REG_IDX arch_reg;
      PHYS_REG_IDX t;
      PHYS_REG_IDX t_old;
      logic        mispredict;
      logic        halt;
      logic [31:0] target_pc;
   } ROB_EXIT_PACKET;

   typedef enum logic [1:0] {RUN, SQUASH, HALTED} RETIRE_STATE;
endpackage

// File: rtl/retire_stage_prefix.sv
// Combinational retire-prefix finder: counts leading valid+completed slots and
// stops after the first slot that carries a stop flag (mispredict or halt).
module retire_prefix #(
   parameter  int N   = 4,
   localparam int NSB = $clog2(N+1)
) (
   input  logic [NSB-1:0] valid_cnt,
   input  logic [N-1:0]   completed,
   input  logic [N-1:0]   stop,
   output logic [NSB-1:0] k,
   output logic [N-1:0]   mask
);
   logic alive;

   always_comb begin
      alive = 1'b1;
      k     = '0;
      mask  = '0;
      for (int i = 0; i < N; i++) begin
         if (alive && (NSB'(i) < valid_cnt) && completed[i]) begin
            mask[i] = 1'b1;
            k       = k + 1'b1;
            if (stop[i]) alive = 1'b0;
         end else begin
            alive = 1'b0;
         end
      end
   end
endmodule

// File: rtl/retire_stage.sv
// In-order commit stage: retires the eligible ROB prefix, frees t_old, updates the map table,
// raises squash after a mispredict and halts after a halt. RETIRE_PERF_EN adds perf counters.
module retire_stage
   import retire_stage_pkg::*;
#(
   parameter  int N        = N_SCALAR,
   parameter  int CNT_BITS = 64,
   localparam int NSB      = $clog2(N+1)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  ROB_EXIT_PACKET [N-1:0]       rob_outputs,
   input  logic [NSB-1:0]               rob_outputs_valid,
   output logic [NSB-1:0]               num_retiring,
   output logic [N-1:0]                 free_valid,
   output logic [N-1:0][PHYS_W-1:0]     free_reg,
   output logic [N-1:0]                 arch_wr_en,
   output logic [N-1:0][ARCH_W-1:0]     arch_wr_reg,
   output logic [N-1:0][PHYS_W-1:0]     arch_wr_preg,
   output logic                         squash,
   output logic [31:0]                  squash_pc,
   output logic                         halted,
`ifdef RETIRE_PERF_EN
   output logic [CNT_BITS-1:0]          perf_cycles,
   output logic [CNT_BITS-1:0]          perf_stall_cycles,
   output logic [CNT_BITS-1:0]          perf_mispredicts,
`endif
   output logic [CNT_BITS-1:0]          retired_count
);
   RETIRE_STATE         state_q, state_d;
   logic                squash_q, squash_d;
   logic                halted_q, halted_d;
   logic [31:0]         squash_pc_q, squash_pc_d;
   logic [CNT_BITS-1:0] retired_count_q, retired_count_d;

   logic [N-1:0]   completed_v, stop_v, pre_mask, ret_mask;
   logic [NSB-1:0] pre_k;
   logic           run_en, halt_hit, mp_hit;
   logic [31:0]    mp_pc;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         completed_v[i] = rob_outputs[i].completed;
         stop_v[i]      = rob_outputs[i].mispredict | rob_outputs[i].halt;
      end
   end

   retire_prefix #(.N(N)) u_prefix (
      .valid_cnt (rob_outputs_valid),
      .completed (completed_v),
      .stop      (stop_v),
      .k         (pre_k),
      .mask      (pre_mask)
   );

   // Outputs are gated by reset so nothing leaks out while it is held low.
   always_comb begin
      run_en       = reset && (state_q == RUN);
      ret_mask     = run_en ? pre_mask : '0;
      num_retiring = run_en ? pre_k : '0;
      free_valid   = '0;
      free_reg     = '0;
      arch_wr_en   = '0;
      arch_wr_reg  = '0;
      arch_wr_preg = '0;
      halt_hit     = 1'b0;
      mp_hit       = 1'b0;
      mp_pc        = '0;
      // Slots are emitted in program order; the map table applies higher indices last.
      for (int i = 0; i < N; i++) begin
         if (ret_mask[i]) begin
            free_valid[i]   = rob_outputs[i].has_dest;
            arch_wr_en[i]   = rob_outputs[i].has_dest;
            free_reg[i]     = rob_outputs[i].t_old;
            arch_wr_reg[i]  = rob_outputs[i].arch_reg;
            arch_wr_preg[i] = rob_outputs[i].t;
            if (rob_outputs[i].halt) halt_hit = 1'b1;
            if (rob_outputs[i].mispredict) begin
               mp_hit = 1'b1;
               mp_pc  = rob_outputs[i].target_pc;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      squash_pc_d = squash_pc_q;
      case (state_q)
         RUN: begin
            if (halt_hit) begin
               state_d = HALTED;
            end else if (mp_hit) begin
               state_d     = SQUASH;
               squash_pc_d = mp_pc;
            end
         end
         SQUASH:  state_d = RUN;
         default: state_d = HALTED;
      endcase
      squash_d        = (state_d == SQUASH);
      halted_d        = (state_d == HALTED);
      retired_count_d = retired_count_q + CNT_BITS'(num_retiring);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= RUN;
         squash_q        <= 1'b0;
         halted_q        <= 1'b0;
         squash_pc_q     <= '0;
         retired_count_q <= '0;
      end else begin
         state_q         <= state_d;
         squash_q        <= squash_d;
         halted_q        <= halted_d;
         squash_pc_q     <= squash_pc_d;
         retired_count_q <= retired_count_d;
      end
   end

   assign squash        = squash_q;
   assign squash_pc     = squash_pc_q;
   assign halted        = halted_q;
   assign retired_count = retired_count_q;

`ifdef RETIRE_PERF_EN
   logic [CNT_BITS-1:0] perf_cycles_q, perf_cycles_d;
   logic [CNT_BITS-1:0] perf_stall_q, perf_stall_d;
   logic [CNT_BITS-1:0] perf_mp_q, perf_mp_d;

   always_comb begin
      perf_cycles_d = perf_cycles_q + 1'b1;
      perf_stall_d  = perf_stall_q;
      perf_mp_d     = perf_mp_q;
      if (run_en && (rob_outputs_valid != '0) && (num_retiring == '0))
         perf_stall_d = perf_stall_q + 1'b1;
      if ((state_q == RUN) && (state_d == SQUASH))
         perf_mp_d = perf_mp_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
         perf_mp_q     <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_stall_q  <= perf_stall_d;
         perf_mp_q     <= perf_mp_d;
      end
   end

   assign perf_cycles       = perf_cycles_q;
   assign perf_stall_cycles = perf_stall_q;
   assign perf_mispredicts  = perf_mp_q;
`endif
endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage (N=4): reset, partial prefix, mispredict squash,
// same-register writes, halt, and reset during squash.
module tb_retire_stage;
   import retire_stage_pkg::*;

   localparam int N  = 4;
   localparam int CB = 64;

   logic                     clock = 1'b0;
   logic                     reset = 1'b0;
   ROB_EXIT_PACKET [N-1:0]   rob_outputs;
   logic [2:0]               rob_outputs_valid;
   logic [2:0]               num_retiring;
   logic [N-1:0]             free_valid;
   logic [N-1:0][PHYS_W-1:0] free_reg;
   logic [N-1:0]             arch_wr_en;
   logic [N-1:0][ARCH_W-1:0] arch_wr_reg;
   logic [N-1:0][PHYS_W-1:0] arch_wr_preg;
   logic                     squash;
   logic [31:0]              squash_pc;
   logic                     halted;
   logic [CB-1:0]            retired_count;
`ifdef RETIRE_PERF_EN
   logic [CB-1:0]            perf_cycles, perf_stall_cycles, perf_mispredicts;
`endif

   int checks   = 0;
   int failures = 0;

   retire_stage #(.N(N), .CNT_BITS(CB)) dut (
      .clock             (clock),
      .reset             (reset),
      .rob_outputs       (rob_outputs),
      .rob_outputs_valid (rob_outputs_valid),
      .num_retiring      (num_retiring),
      .free_valid        (free_valid),
      .free_reg          (free_reg),
      .arch_wr_en        (arch_wr_en),
      .arch_wr_reg       (arch_wr_reg),
      .arch_wr_preg      (arch_wr_preg),
      .squash            (squash),
      .squash_pc         (squash_pc),
      .halted            (halted),
`ifdef RETIRE_PERF_EN
      .perf_cycles       (perf_cycles),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_mispredicts  (perf_mispredicts),
`endif
      .retired_count     (retired_count)
   );

   always #5 clock = ~clock;

   function automatic ROB_EXIT_PACKET mk(input logic c, input logic hd, input logic [4:0] ar,
                                         input logic [5:0] t, input logic [5:0] told,
                                         input logic mp, input logic h, input logic [31:0] pc);
      ROB_EXIT_PACKET p;
      p.completed = c;  p.has_dest = hd; p.arch_reg = ar; p.t = t; p.t_old = told;
      p.mispredict = mp; p.halt = h; p.target_pc = pc;
      return p;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after a falling edge; #1 lets combinational outputs settle.
   task automatic next_cycle();
      @(negedge clock);
      #1;
   endtask

   initial begin
      // 1: reset held with live inputs
      for (int i = 0; i < N; i++) rob_outputs[i] = mk(1, 1, 5'(i+1), 6'(i+10), 6'(i+30), 0, 0, 0);
      rob_outputs_valid = 3'd4;
      repeat (3) next_cycle();
      check("rst_num_retiring", 64'(num_retiring), 0);
      check("rst_free_valid", 64'(free_valid), 0);
      check("rst_squash", 64'(squash), 0);
      check("rst_halted", 64'(halted), 0);
      check("rst_retired_count", retired_count, 0);

      // 2: completed 1,1,0,1 -> two retire
      reset = 1'b1;
      rob_outputs[2].completed = 1'b0;
      #1;
      check("pfx_num_retiring", 64'(num_retiring), 2);
      check("pfx_free_valid", 64'(free_valid), 64'b0011);
      check("pfx_free_reg1", 64'(free_reg[1]), 31);
      check("pfx_arch_wr_reg1", 64'(arch_wr_reg[1]), 2);
      check("pfx_free_reg2_zero", 64'(free_reg[2]), 0);
      next_cycle();
      check("pfx_retired_count", retired_count, 2);
      rob_outputs_valid = 3'd0;
      #1;
      check("empty_num_retiring", 64'(num_retiring), 0);

      // 3: mispredict in slot 1
      rob_outputs[0] = mk(1, 1, 5'd1, 6'd14, 6'd40, 0, 0, 0);
      rob_outputs[1] = mk(1, 1, 5'd2, 6'd15, 6'd41, 1, 0, 32'h100);
      rob_outputs[2] = mk(1, 1, 5'd3, 6'd16, 6'd42, 0, 0, 0);
      rob_outputs_valid = 3'd3;
      #1;
      check("mp_num_retiring", 64'(num_retiring), 2);
      check("mp_squash_before", 64'(squash), 0);
      next_cycle();
      check("mp_squash", 64'(squash), 1);
      check("mp_squash_pc", 64'(squash_pc), 64'h100);
      check("mp_squash_num_retiring", 64'(num_retiring), 0);
      check("mp_retired_count", retired_count, 4);
      rob_outputs_valid = 3'd0;
      next_cycle();
      check("mp_squash_done", 64'(squash), 0);

      // 5: two writes to x5
      rob_outputs[0] = mk(1, 1, 5'd5, 6'd12, 6'd20, 0, 0, 0);
      rob_outputs[1] = mk(1, 1, 5'd5, 6'd13, 6'd21, 0, 0, 0);
      rob_outputs_valid = 3'd2;
      #1;
      check("waw_arch_wr_en", 64'(arch_wr_en), 64'b0011);
      check("waw_arch_wr_reg1", 64'(arch_wr_reg[1]), 5);
      check("waw_arch_wr_preg0", 64'(arch_wr_preg[0]), 12);
      check("waw_arch_wr_preg1", 64'(arch_wr_preg[1]), 13);
      check("waw_free_reg0", 64'(free_reg[0]), 20);
      check("waw_free_reg1", 64'(free_reg[1]), 21);
      next_cycle();
      check("waw_retired_count", retired_count, 6);

      // 4: halt in slot 0, slot 1 completed
      rob_outputs[0] = mk(1, 0, 5'd0, 6'd0, 6'd0, 0, 1, 0);
      rob_outputs[1] = mk(1, 1, 5'd7, 6'd17, 6'd27, 0, 0, 0);
      #1;
      check("halt_num_retiring", 64'(num_retiring), 1);
      check("halt_free_valid", 64'(free_valid), 0);
      next_cycle();
      check("halt_halted", 64'(halted), 1);
      check("halt_retired_count", retired_count, 7);
      rob_outputs[0] = mk(1, 1, 5'd8, 6'd18, 6'd28, 0, 0, 0);
      rob_outputs_valid = 3'd4;
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         check("halt_hold_num_retiring", 64'(num_retiring), 0);
      end
      check("halt_hold_arch_wr_en", 64'(arch_wr_en), 0);
      check("halt_hold_halted", 64'(halted), 1);
      check("halt_hold_retired_count", retired_count, 7);

      // 6: reset during squash
      reset = 1'b0;
      next_cycle();
      check("rst2_halted", 64'(halted), 0);
      reset = 1'b1;
      rob_outputs[0] = mk(1, 0, 5'd0, 6'd0, 6'd0, 1, 0, 32'h200);
      rob_outputs_valid = 3'd1;
      #1;
      check("sq2_num_retiring", 64'(num_retiring), 1);
      next_cycle();
      check("sq2_squash", 64'(squash), 1);
      check("sq2_squash_pc", 64'(squash_pc), 64'h200);
`ifdef RETIRE_PERF_EN
      check("sq2_perf_mispredicts", perf_mispredicts, 1);
`endif
      #1 reset = 1'b0;
      #1;
      check("sq2_rst_squash", 64'(squash), 0);
      check("sq2_rst_squash_pc", 64'(squash_pc), 0);
      check("sq2_rst_retired_count", retired_count, 0);
`ifdef RETIRE_PERF_EN
      check("sq2_rst_perf_mispredicts", perf_mispredicts, 0);
`endif
      next_cycle();
      reset = 1'b1;
      rob_outputs[0] = mk(1, 1, 5'd9, 6'd19, 6'd29, 0, 0, 0);
      #1;
      check("post_rst_run_num_retiring", 64'(num_retiring), 1);
      next_cycle();
      check("post_rst_squash", 64'(squash), 0);
      check("post_rst_retired_count", retired_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
